// File: rtl/cntr_config_param.sv
// ============================================================================
// Module      : cntr_config_param
// Description : Configurable up/down counter with start/stop control, STOP/WRAP
//               modes and a programmable step clamped at the end value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cntr_config_param #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] cntr_start,
  input  logic [WIDTH-1:0] ind_val,
  input  logic [WIDTH-1:0] incr,
  output logic [WIDTH-1:0] cntr_out,
  output logic             ind,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cntr, w_cntr_nxt;
  logic             r_dir, r_mode;
  logic [WIDTH-1:0] r_start, r_end, r_incr;
  logic             r_done, w_done_nxt;
  logic             r_cfg_err, w_cfg_err_nxt;
  logic             w_cfg_ok, w_accept;
  logic             w_at_end;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_reached;

  assign w_cfg_ok = (incr != '0) &&
                    (dir ? (cntr_start >= ind_val) : (cntr_start <= ind_val));
  assign w_accept = start && !stop && w_cfg_ok;
  assign w_at_end = (r_cntr == r_end);

  // Extra bit catches carry/borrow so a step can never silently wrap past the end.
  assign w_sum  = {1'b0, r_cntr} + {1'b0, r_incr};
  assign w_diff = {1'b0, r_cntr} - {1'b0, r_incr};
  assign w_reached = r_dir ? (w_diff[WIDTH] || (w_diff[WIDTH-1:0] <= r_end))
                           : (w_sum[WIDTH]  || (w_sum[WIDTH-1:0]  >= r_end));

  always_comb begin
    w_state_nxt   = r_state;
    w_cntr_nxt    = r_cntr;
    w_done_nxt    = 1'b0;
    w_cfg_err_nxt = 1'b0;
    if (stop) begin
      w_state_nxt = IDLE;
    end else if (start) begin
      if (w_cfg_ok) begin
        w_state_nxt = RUN;
        w_cntr_nxt  = cntr_start;
        w_done_nxt  = (cntr_start == ind_val);
      end else begin
        w_cfg_err_nxt = 1'b1;
      end
    end else if (r_state == RUN && en) begin
      if (w_at_end) begin
        // Only reachable when loaded already at the end, or after a WRAP hit.
        if (r_mode) w_cntr_nxt  = r_start;
        else        w_state_nxt = HALT;
      end else if (w_reached) begin
        w_cntr_nxt = r_end;
        w_done_nxt = 1'b1;
        if (!r_mode) w_state_nxt = HALT;
      end else begin
        w_cntr_nxt = r_dir ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cntr    <= '0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cntr    <= w_cntr_nxt;
      r_done    <= w_done_nxt;
      r_cfg_err <= w_cfg_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_start <= '0;
      r_end   <= '0;
      r_incr  <= '0;
    end else if (w_accept) begin
      r_dir   <= dir;
      r_mode  <= mode;
      r_start <= cntr_start;
      r_end   <= ind_val;
      r_incr  <= incr;
    end
  end

  assign cntr_out = r_cntr;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign busy     = (r_state == RUN);
  assign ind      = (r_state != IDLE) && w_at_end;

endmodule

`default_nettype wire

// File: tb/tb_cntr_config_param.sv
// ============================================================================
// Module      : tb_cntr_config_param
// Description : Directed self-checking bench for cntr_config_param (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cntr_config_param;

  localparam int c_width = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0, stop = 1'b0, en = 1'b1, dir = 1'b0, mode = 1'b0;
  logic [c_width-1:0] cntr_start = '0, ind_val = '0, incr = '0;
  logic [c_width-1:0] cntr_out;
  logic               ind, done, busy, cfg_err;

  int r_tests = 0;
  int r_fails = 0;

  cntr_config_param #(.WIDTH(c_width)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .en(en),
    .dir(dir), .mode(mode), .cntr_start(cntr_start), .ind_val(ind_val),
    .incr(incr), .cntr_out(cntr_out), .ind(ind), .done(done), .busy(busy),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    r_tests++;
    if (got !== exp) begin
      r_fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic d, input logic m, input int s, input int e, input int st);
    dir = d; mode = m; cntr_start = s[c_width-1:0]; ind_val = e[c_width-1:0]; incr = st[c_width-1:0];
  endtask

  // Checks counter value, done and busy after one clock edge.
  task automatic step_chk(input string tag, input int v, input int d, input int b);
    tick();
    check({tag, ".cnt"},  int'(cntr_out), v);
    check({tag, ".done"}, int'(done), d);
    check({tag, ".busy"}, int'(busy), b);
  endtask

  initial begin
    #12;
    check("rst.cnt", int'(cntr_out), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.ind", int'(ind), 0);
    check("rst.done", int'(done), 0);
    reset_n = 1'b1;
    tick();

    // Up/STOP 2 -> 10 step 3
    cfg(1'b0, 1'b0, 2, 10, 3);
    start = 1'b1;
    step_chk("up0", 2, 0, 1);
    start = 1'b0;
    step_chk("up1", 5, 0, 1);
    step_chk("up2", 8, 0, 1);
    check("up2.ind", int'(ind), 0);
    step_chk("up3", 10, 1, 0);
    check("up3.ind", int'(ind), 1);
    step_chk("up4", 10, 0, 0);
    check("up4.ind", int'(ind), 1);

    // Down/WRAP 9 -> 1 step 4
    cfg(1'b1, 1'b1, 9, 1, 4);
    start = 1'b1;
    step_chk("dn0", 9, 0, 1);
    start = 1'b0;
    step_chk("dn1", 5, 0, 1);
    step_chk("dn2", 1, 1, 1);
    check("dn2.ind", int'(ind), 1);
    step_chk("dn3", 9, 0, 1);
    step_chk("dn4", 5, 0, 1);
    step_chk("dn5", 1, 1, 1);

    // Carry clamp 13 -> 15 step 4
    cfg(1'b0, 1'b0, 13, 15, 4);
    start = 1'b1;
    step_chk("cy0", 13, 0, 1);
    start = 1'b0;
    step_chk("cy1", 15, 1, 0);
    step_chk("cy2", 15, 0, 0);

    // Abort to IDLE, then rejected configs
    stop = 1'b1;
    step_chk("stp", 15, 0, 0);
    stop = 1'b0;
    check("stp.ind", int'(ind), 0);
    cfg(1'b0, 1'b0, 12, 4, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err1.pulse", int'(cfg_err), 1);
    check("err1.cnt", int'(cntr_out), 15);
    check("err1.busy", int'(busy), 0);
    tick();
    check("err1.clr", int'(cfg_err), 0);
    cfg(1'b0, 1'b0, 1, 5, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err2.pulse", int'(cfg_err), 1);
    check("err2.cnt", int'(cntr_out), 15);
    check("err2.busy", int'(busy), 0);
    tick();
    check("err2.clr", int'(cfg_err), 0);

    // Gating and priority, 0 -> 8 step 1
    cfg(1'b0, 1'b0, 0, 8, 1);
    start = 1'b1;
    step_chk("g0", 0, 0, 1);
    start = 1'b0;
    step_chk("g1", 1, 0, 1);
    step_chk("g2", 2, 0, 1);
    en = 1'b0;
    for (int i = 0; i < 3; i++) step_chk("gfrz", 2, 0, 1);
    en = 1'b1;
    step_chk("g3", 3, 0, 1);
    start = 1'b1; stop = 1'b1;
    step_chk("pri", 3, 0, 0);
    stop = 1'b0;
    step_chk("rs0", 0, 0, 1);
    start = 1'b0;
    step_chk("rs1", 1, 0, 1);
    step_chk("rs2", 2, 0, 1);
    start = 1'b1;
    step_chk("rld", 0, 0, 1);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step_chk("cnt", i, 0, 1);

    // Asynchronous reset mid-run at cntr_out=5
    #2;
    reset_n = 1'b0;
    #1;
    check("arst.cnt", int'(cntr_out), 0);
    check("arst.busy", int'(busy), 0);
    check("arst.done", int'(done), 0);
    tick();
    reset_n = 1'b1;
    step_chk("post0", 0, 0, 0);
    step_chk("post1", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
